// File: rtl/pong_graph_anim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pong_graph_anim                                                  |
// | Purpose  : Pong pixel-graphics and animation stage. Moves the paddle from   |
// |            the push-buttons and bounces the ball once per frame, renders    |
// |            the registered RGB colour of the current pixel and emits         |
// |            single-cycle hit / miss events for the score logic.              |
// | Ports    : clk, reset (async, active-high)                                   |
// |            btn[1:0]        {down, up}, synchronised levels                   |
// |            video_on        visible-area flag from the timing generator      |
// |            p_tick          25 MHz pixel strobe                               |
// |            pixel_x/_y      current pixel coordinates                         |
// |            rgb[2:0]        registered {R,G,B}                                |
// |            hit / miss      one-clk pulses after the frame tick               |
// | Options  : PONG_ROUND_BALL_EN - mask the ball with an 8x8 round ROM          |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module pong_graph_anim #(
  parameter int PADDLE_V = 4,
  parameter int BALL_V   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       video_on,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [2:0] rgb,
  output logic       hit,
  output logic       miss
);

  localparam logic [9:0]  PAD_Y_INIT     = 10'd204;
  localparam logic [9:0]  BALL_X_INIT    = 10'd320;
  localparam logic [9:0]  BALL_Y_INIT    = 10'd240;
  localparam logic [9:0]  V_POS          = 10'(BALL_V);
  localparam logic [9:0]  V_NEG          = 10'(-BALL_V);
  localparam logic [9:0]  PAD_STEP       = 10'(PADDLE_V);
  localparam logic [10:0] PAD_DOWN_LIMIT = 11'(479 - PADDLE_V);

  logic [9:0] pad_y_q,  pad_y_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic [9:0] dx_q,     dx_d;
  logic [9:0] dy_q,     dy_d;
  logic [2:0] rgb_q,    rgb_d;
  logic       hit_q,    hit_d;
  logic       miss_q,   miss_d;

  logic        ref_tick;
  logic        dx_pos;
  logic [10:0] pad_bot;
  logic [10:0] ball_r;
  logic [10:0] ball_b;
  logic        wall_on;
  logic        pad_on;
  logic        ball_sq_on;
  logic        ball_on;

  // One clk per frame, inside vertical blanking, so motion never tears.
  assign ref_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd481);

  // Far edges widened by one bit so that +71 / +7 never wrap.
  assign pad_bot = {1'b0, pad_y_q}  + 11'd71;
  assign ball_r  = {1'b0, ball_x_q} + 11'd7;
  assign ball_b  = {1'b0, ball_y_q} + 11'd7;
  assign dx_pos  = !dx_q[9] && (dx_q != 10'd0);

  // ---------------------------------------------------------------------------
  // Motion: paddle, ball velocity and position, hit / miss events
  // ---------------------------------------------------------------------------
  always_comb begin
    pad_y_d  = pad_y_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (ref_tick) begin
      case (btn)
        2'b10: if (pad_bot < PAD_DOWN_LIMIT) pad_y_d = pad_y_q + PAD_STEP;
        2'b01: if (pad_y_q > PAD_STEP)       pad_y_d = pad_y_q - PAD_STEP;
        default: ;
      endcase

      if (ball_x_q > 10'd639) begin
        // Ball left the right edge: serve again from the centre.
        ball_x_d = BALL_X_INIT;
        ball_y_d = BALL_Y_INIT;
        dx_d     = V_POS;
        dy_d     = V_POS;
        miss_d   = 1'b1;
      end else begin
        if (ball_y_q <= 10'd1)
          dy_d = V_POS;
        else if (ball_b >= 11'd478)
          dy_d = V_NEG;

        if (ball_x_q <= 10'd35) begin
          dx_d = V_POS;
        end else if ((ball_r >= 11'd600) && (ball_r <= 11'd603) &&
                     (ball_b >= {1'b0, pad_y_q}) &&
                     ({1'b0, ball_y_q} <= pad_bot) && dx_pos) begin
          dx_d  = V_NEG;
          hit_d = 1'b1;
        end

        // Position advances with the freshly chosen velocity (mod 1024).
        ball_x_d = ball_x_q + dx_d;
        ball_y_d = ball_y_q + dy_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rendering
  // ---------------------------------------------------------------------------
  assign wall_on    = (pixel_x >= 10'd32) && (pixel_x <= 10'd35);
  assign pad_on     = (pixel_x >= 10'd600) && (pixel_x <= 10'd603) &&
                      (pixel_y >= pad_y_q) && ({1'b0, pixel_y} <= pad_bot);
  assign ball_sq_on = (pixel_x >= ball_x_q) && ({1'b0, pixel_x} <= ball_r) &&
                      (pixel_y >= ball_y_q) && ({1'b0, pixel_y} <= ball_b);

`ifdef PONG_ROUND_BALL_EN
  logic [2:0] rom_row;
  logic [2:0] rom_col;
  logic [7:0] rom_bits;

  // Offsets inside the ball only need 3 bits, so subtract the low bits alone.
  assign rom_row = pixel_y[2:0] - ball_y_q[2:0];
  assign rom_col = pixel_x[2:0] - ball_x_q[2:0];

  always_comb begin
    case (rom_row)
      3'd0, 3'd7: rom_bits = 8'b0011_1100;
      3'd1, 3'd6: rom_bits = 8'b0111_1110;
      default:    rom_bits = 8'b1111_1111;
    endcase
  end

  // Column 0 is the MSB of the ROM row.
  assign ball_on = ball_sq_on && rom_bits[3'd7 - rom_col];
`else
  assign ball_on = ball_sq_on;
`endif

  always_comb begin
    rgb_d = 3'b110;
    if (!video_on)
      rgb_d = 3'b000;
    else if (wall_on)
      rgb_d = 3'b001;
    else if (pad_on)
      rgb_d = 3'b010;
    else if (ball_on)
      rgb_d = 3'b100;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_y_q  <= PAD_Y_INIT;
      ball_x_q <= BALL_X_INIT;
      ball_y_q <= BALL_Y_INIT;
      dx_q     <= V_POS;
      dy_q     <= V_POS;
      rgb_q    <= 3'b000;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      pad_y_q  <= pad_y_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      rgb_q    <= rgb_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign rgb  = rgb_q;
  assign hit  = hit_q;
  assign miss = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_graph_anim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pong_graph_anim                                               |
// | Purpose  : Self-checking bench for pong_graph_anim. Frames are compressed:  |
// |            a few probe pixels followed by the frame-tick pixel (0,481).     |
// |            A behavioural game model predicts colours and hit / miss.       |
// | Options  : PONG_ROUND_BALL_EN - selects the round-ball expectations         |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pong_graph_anim;

  localparam int PV = 4;
  localparam int BV = 2;
`ifdef PONG_ROUND_BALL_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [2:0] rgb;
  logic       hit;
  logic       miss;

  always #10 clk = ~clk;

  pong_graph_anim #(.PADDLE_V(PV), .BALL_V(BV)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .video_on (video_on),
    .p_tick   (p_tick),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .rgb      (rgb),
    .hit      (hit),
    .miss     (miss)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: plain integers, the paddle top, ball corner and velocities.
  int m_pad, m_bx, m_by, m_dx, m_dy;
  int m_hits = 0, m_misses = 0, d_hits = 0, d_misses = 0;
  int rom [8] = '{60, 126, 255, 255, 255, 255, 126, 60};

  typedef struct {
    int x;
    int y;
    bit vo;
    int exp_rgb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pad = 204; m_bx = 320; m_by = 240; m_dx = BV; m_dy = BV;
  endtask

  function automatic int colour(int x, int y, bit vo);
    if (!vo) return 0;
    if (x >= 32 && x <= 35) return 1;
    if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 71) return 2;
    if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) begin
      if (ROUND && (((rom[y - m_by] >> (7 - (x - m_bx))) & 1) == 0)) return 6;
      return 4;
    end
    return 6;
  endfunction

  // One frame of game rules applied at the tick.
  task automatic m_step(input logic [1:0] b, output bit eh, output bit em);
    eh = 1'b0;
    em = 1'b0;
    if (b == 2'b10 && m_pad + 71 < 479 - PV) m_pad += PV;
    else if (b == 2'b01 && m_pad > PV)      m_pad -= PV;
    if (m_bx > 639) begin
      m_reset_ball();
      em = 1'b1;
    end else begin
      if (m_by <= 1) m_dy = BV;
      else if (m_by + 7 >= 478) m_dy = -BV;
      if (m_bx <= 35) m_dx = BV;
      else if (m_bx + 7 >= 600 && m_bx + 7 <= 603 && m_by + 7 >= m_pad &&
               m_by <= m_pad + 71 && m_dx > 0) begin
        m_dx = -BV;
        eh = 1'b1;
      end
      m_bx = (m_bx + m_dx + 1024) % 1024;
      m_by = (m_by + m_dy + 1024) % 1024;
    end
  endtask

  task automatic m_reset_ball();
    m_bx = 320; m_by = 240; m_dx = BV; m_dy = BV;
  endtask

  task automatic cyc(input logic [1:0] b, input int x, input int y, input bit vo, input bit pt);
    @(negedge clk);
    btn      = b;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vo;
    p_tick   = pt;
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input int x, input int y, input bit vo);
    cyc(2'(($urandom % 4)), x, y, vo, 1'b1);
    check(name, rgb, colour(x, y, vo));
  endtask

  task automatic do_frame(input logic [1:0] b);
    bit eh, em;
    for (int k = 0; k < 3; k++) begin
      int x, y, mode;
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      end else if (mode == 1) begin
        x = m_bx - 2 + $urandom_range(0, 11); y = m_by - 2 + $urandom_range(0, 11);
      end else begin
        x = 598 + $urandom_range(0, 7); y = m_pad - 2 + $urandom_range(0, 75);
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (x > 799) x = 799;
      if (y > 524) y = 524;
      if (x == 0 && y == 481) y = 480;
      cyc(b, x, y, ($urandom % 4) != 0, 1'($urandom % 2));
      check("probe_rgb", rgb, colour(x, y, video_on));
      check("probe_hit_idle", hit, 0);
      check("probe_miss_idle", miss, 0);
    end
    // Frame tick.
    cyc(b, 0, 481, 1'b0, 1'b1);
    m_step(b, eh, em);
    if (eh) m_hits++;
    if (em) m_misses++;
    if (hit)  d_hits++;
    if (miss) d_misses++;
    check("tick_hit", hit, eh);
    check("tick_miss", miss, em);
    check("tick_rgb_blank", rgb, 0);
    // Same coordinates without the pixel strobe: no second tick, pulses end.
    cyc(b, 0, 481, 1'b0, 1'b0);
    check("pulse_hit_width", hit, 0);
    check("pulse_miss_width", miss, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  function automatic logic [1:0] track_btn();
    int c, t;
    c = m_pad + 36;
    t = m_by + 4;
    if (t > c + 2) return 2'b10;
    if (t < c - 2) return 2'b01;
    return 2'b00;
  endfunction

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{33, 100, 1'b1, 1};
    vecs[1]  = '{35, 479, 1'b1, 1};
    vecs[2]  = '{36, 10, 1'b1, 6};
    vecs[3]  = '{31, 10, 1'b1, 6};
    vecs[4]  = '{601, 204, 1'b1, 2};
    vecs[5]  = '{603, 275, 1'b1, 2};
    vecs[6]  = '{603, 276, 1'b1, 6};
    vecs[7]  = '{601, 203, 1'b1, 6};
    vecs[8]  = '{700, 100, 1'b1, 6};
    vecs[9]  = '{100, 500, 1'b0, 0};
    vecs[10] = '{33, 100, 1'b0, 0};
    vecs[11] = '{320, 240, 1'b1, ROUND ? 6 : 4};
    vecs[12] = '{323, 240, 1'b1, 4};
    vecs[13] = '{327, 247, 1'b1, ROUND ? 6 : 4};
    vecs[14] = '{324, 244, 1'b1, 4};
    vecs[15] = '{328, 240, 1'b1, 6};
    vecs[16] = '{320, 248, 1'b1, 6};

    reset = 1'b1; btn = 2'b00; video_on = 1'b1; p_tick = 1'b1;
    pixel_x = 10'd700; pixel_y = 10'd100;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", rgb, 0);
    check("reset_hit", hit, 0);
    check("reset_miss", miss, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();

    // Rendering at the reset state, table-driven.
    for (int i = 0; i < 17; i++) begin
      cyc(2'b00, vecs[i].x, vecs[i].y, vecs[i].vo, 1'b1);
      check($sformatf("vec_rgb[%0d]", i), rgb, vecs[i].exp_rgb);
    end

    // Asynchronous reset mid-frame with both buttons held.
    for (int f = 0; f < 5; f++) do_frame(2'($urandom % 4));
    cyc(2'b11, 700, 100, 1'b1, 1'b1);
    check("pre_reset_rgb", rgb, 6);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_reset_rgb", rgb, 0);
    check("async_reset_hit", hit, 0);
    check("async_reset_miss", miss, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    do_frame(2'b11);
    do_frame(2'b11);
    cyc(2'b11, 324, 244, 1'b1, 1'b1);
    check("two_frames_ball_corner", rgb, ROUND ? 6 : 4);
    cyc(2'b11, 327, 244, 1'b1, 1'b1);
    check("two_frames_ball_mid", rgb, 4);
    cyc(2'b11, 323, 244, 1'b1, 1'b1);
    check("two_frames_ball_left", rgb, 6);
    cyc(2'b11, 601, 204, 1'b1, 1'b1);
    check("two_frames_pad_top", rgb, 2);
    cyc(2'b11, 601, 203, 1'b1, 1'b1);
    check("two_frames_pad_above", rgb, 6);

    // Paddle limits.
    for (int f = 0; f < 100; f++) do_frame(2'b10);
    probe("pad_bottom_top",  602, m_pad, 1'b1);
    probe("pad_bottom_above", 602, m_pad - 1, 1'b1);
    probe("pad_bottom_low",  602, m_pad + 71, 1'b1);
    probe("pad_bottom_below", 602, m_pad + 72, 1'b1);
    for (int f = 0; f < 200; f++) do_frame(2'b01);
    probe("pad_top_top",   602, m_pad, 1'b1);
    probe("pad_top_above", 602, m_pad - 1, 1'b1);
    probe("pad_top_low",   602, m_pad + 71, 1'b1);
    probe("pad_top_below", 602, m_pad + 72, 1'b1);

    // Paddle tracks the ball: bounces off the paddle.
    do_reset();
    for (int f = 0; f < 420; f++) do_frame(track_btn());
    check("hit_seen", m_hits > 0, 1);

    // Paddle parked at the top: the ball passes and is served again.
    do_reset();
    for (int f = 0; f < 200; f++) do_frame(2'b01);
    check("miss_seen", m_misses > 0, 1);

    // Random buttons.
    do_reset();
    for (int f = 0; f < 300; f++) do_frame(2'($urandom % 4));

    check("hit_total", d_hits, m_hits);
    check("miss_total", d_misses, m_misses);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
